// File: rtl/cgra_issue_sequencer_pkg.sv
// Shared widths and sequencer state encoding for the CGRA lane issue sequencer.
package cgra_issue_sequencer_pkg;

    localparam int DW_INST  = 32;
    localparam int DW_INT   = 32;
    localparam int DW_RFADD = 6;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EXEC,
        VEC,
        DONE
    } seq_state_t;

    localparam logic [DW_INST-1:0] HALT_INSTR = '0;

endpackage

// File: rtl/cgra_issue_sequencer_vec_elem_counter.sv
// Element counter for vector streaming: holds the ITR length and the current
// element offset, and produces the beat valid/last qualifiers.
module vec_elem_counter
    import cgra_issue_sequencer_pkg::*;
#(
    parameter int dwidth_RFadd = DW_RFADD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_itr,
    input  logic [dwidth_RFadd-1:0] itr_in,
    input  logic                    start_vec,
    input  logic                    active,
    input  logic                    ready,
    output logic [dwidth_RFadd-1:0] elem_idx,
    output logic                    vec_valid,
    output logic                    vec_last,
    output logic                    last_accept,
    output logic                    itr_zero
);

    logic [dwidth_RFadd-1:0] itr_q;
    logic [dwidth_RFadd-1:0] elem_cnt;

    // itr_q comes out of reset as 1 so a vector op issued before any vsetivli yields one beat
    always_ff @(posedge clk) begin
        if (!rst) begin
            itr_q    <= dwidth_RFadd'(1);
            elem_cnt <= '0;
        end else begin
            if (load_itr) begin
                itr_q <= itr_in;
            end
            if (start_vec) begin
                elem_cnt <= '0;
            end else if (active && ready) begin
                elem_cnt <= elem_cnt + dwidth_RFadd'(1);
            end
        end
    end

    assign elem_idx    = elem_cnt;
    assign vec_valid   = active;
    assign vec_last    = active && (elem_cnt == itr_q - dwidth_RFadd'(1));
    assign last_accept = vec_last && ready;
    assign itr_zero    = (itr_q == '0);

endmodule

// File: rtl/cgra_issue_sequencer.sv
// Program sequencer for one CGRA lane: PC, instruction fetch, branch resolution
// and the hold of the PC while a vector instruction streams its elements.
module cgra_issue_sequencer
    import cgra_issue_sequencer_pkg::*;
#(
    parameter int dwidth_inst  = DW_INST,
    parameter int dwidth_int   = DW_INT,
    parameter int dwidth_RFadd = DW_RFADD,
    parameter int IMEM_AWIDTH  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [IMEM_AWIDTH-1:0]  prog_base,
    output logic                    imem_en,
    output logic [IMEM_AWIDTH-1:0]  imem_addr,
    input  logic [dwidth_inst-1:0]  imem_rdata,
    output logic [dwidth_inst-1:0]  instr,
    output logic                    issue,
    input  logic                    is_not_vect,
    input  logic                    is_bne,
    input  logic [11:0]             branch_immediate,
    input  logic                    wen_ITR,
    input  logic [dwidth_RFadd-1:0] ITR,
    input  logic [dwidth_int-1:0]   rs1_val,
    input  logic [dwidth_int-1:0]   rs2_val,
    input  logic                    vec_ready,
    output logic                    vec_valid,
    output logic                    vec_last,
    output logic [dwidth_RFadd-1:0] elem_idx,
    output logic                    busy,
    output logic                    done
);

    seq_state_t             state, state_next;
    logic [IMEM_AWIDTH-1:0] pc, pc_next, pc_inc;
    logic                   load_itr, start_vec, vec_active, vec_done, itr_zero;

    // B-type immediate is a byte offset in half-word units; the PC counts 32-bit words
    function automatic logic [IMEM_AWIDTH-1:0] branch_offset(input logic [11:0] imm);
        logic signed [12:0] byte_off;
        logic signed [12:0] word_off;
        byte_off = $signed({imm, 1'b0});
        word_off = byte_off >>> 2;
        return IMEM_AWIDTH'({{IMEM_AWIDTH{word_off[12]}}, word_off});
    endfunction

    assign pc_inc = pc + IMEM_AWIDTH'(1);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        load_itr   = 1'b0;
        start_vec  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    pc_next    = prog_base;
                    state_next = FETCH;
                end
            end
            FETCH: state_next = WAIT;
            WAIT:  state_next = EXEC;
            EXEC: begin
                state_next = FETCH;
                if (instr == dwidth_inst'(HALT_INSTR)) begin
                    state_next = DONE;
                end else if (!is_not_vect) begin
                    // vector path takes precedence over a simultaneous wen_ITR
                    if (itr_zero) begin
                        pc_next = pc_inc;
                    end else begin
                        start_vec  = 1'b1;
                        state_next = VEC;
                    end
                end else if (wen_ITR) begin
                    load_itr = 1'b1;
                    pc_next  = pc_inc;
                end else if (is_bne && (rs1_val != rs2_val)) begin
                    pc_next = pc + branch_offset(branch_immediate);
                end else begin
                    pc_next = pc_inc;
                end
            end
            VEC: begin
                if (vec_done) begin
                    pc_next    = pc_inc;
                    state_next = FETCH;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // instr is only loaded in WAIT, so it stays stable across EXEC and all VEC beats
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            pc    <= '0;
            instr <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == WAIT) begin
                instr <= imem_rdata;
            end
        end
    end

    assign imem_en    = (state == FETCH);
    assign imem_addr  = pc;
    assign issue      = (state == EXEC);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign vec_active = (state == VEC);

    vec_elem_counter #(
        .dwidth_RFadd(dwidth_RFadd)
    ) u_vec_elem_counter (
        .clk        (clk),
        .rst        (rst),
        .load_itr   (load_itr),
        .itr_in     (ITR),
        .start_vec  (start_vec),
        .active     (vec_active),
        .ready      (vec_ready),
        .elem_idx   (elem_idx),
        .vec_valid  (vec_valid),
        .vec_last   (vec_last),
        .last_accept(vec_done),
        .itr_zero   (itr_zero)
    );

endmodule

// File: tb/tb_cgra_issue_sequencer.sv
// Bench for cgra_issue_sequencer: BRAM and decoder stand-ins plus a program-level
// reference model that predicts fetch order, issued words and vector beats.
module tb_cgra_issue_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  prog_base;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        issue;
    logic        is_not_vect;
    logic        is_bne;
    logic [11:0] branch_immediate;
    logic        wen_ITR;
    logic [5:0]  ITR;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        vec_ready;
    logic        vec_valid;
    logic        vec_last;
    logic [5:0]  elem_idx;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    cgra_issue_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .prog_base       (prog_base),
        .imem_en         (imem_en),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .issue           (issue),
        .is_not_vect     (is_not_vect),
        .is_bne          (is_bne),
        .branch_immediate(branch_immediate),
        .wen_ITR         (wen_ITR),
        .ITR             (ITR),
        .rs1_val         (rs1_val),
        .rs2_val         (rs2_val),
        .vec_ready       (vec_ready),
        .vec_valid       (vec_valid),
        .vec_last        (vec_last),
        .elem_idx        (elem_idx),
        .busy            (busy),
        .done            (done)
    );

    // Bench instruction format: kind[2:0] take[3] imm[15:4] itr[21:16] tag[31:24]
    // kind: 1 addi, 2 vsetivli, 3 bne, 4 vector op; all-zero word is HALT.
    assign is_not_vect      = (instr[2:0] != 3'd4);
    assign is_bne           = (instr[2:0] == 3'd3);
    assign wen_ITR          = (instr[2:0] == 3'd2);
    assign branch_immediate = instr[15:4];
    assign ITR              = instr[21:16];
    assign rs1_val          = {24'h0, instr[31:24]};
    assign rs2_val          = rs1_val + {31'h0, instr[3]};

    function automatic logic [31:0] enc(input logic [2:0] kind, input logic take,
                                        input logic [11:0] imm, input logic [5:0] itr,
                                        input logic [7:0] tag);
        return {tag, 2'b00, itr, imm, take, kind};
    endfunction

    logic [31:0] mem [0:1023];

    int n_vec  = 0;
    int n_fail = 0;

    // Monitor state
    int          mon_fetch[$];
    logic [31:0] mon_issue[$];
    int          mon_beats[$];
    int          busy_cycles, vec_cycles, done_count;
    int          ready_pat[$];
    bit          ready_rand   = 1'b0;
    bit          ready_force0 = 1'b0;
    bit          rd_pend      = 1'b0;
    logic [9:0]  rd_addr;

    // Model state
    int          exp_fetch[$];
    logic [31:0] exp_issue[$];
    int          exp_beats[$];
    int          model_itr = 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int word_off(input logic [11:0] imm);
        int b;
        b = int'($signed(imm)) * 2;
        return (b >= 0) ? b / 4 : -((-b + 3) / 4);
    endfunction

    task automatic model_run(input int base);
        int pc;
        logic [31:0] w;
        pc = base;
        exp_fetch.delete(); exp_issue.delete(); exp_beats.delete();
        for (int n = 0; n < 300; n++) begin
            w = mem[pc];
            exp_fetch.push_back(pc);
            exp_issue.push_back(w);
            if (w == 32'h0) break;
            case (w[2:0])
                3'd4: begin
                    for (int i = 0; i < model_itr; i++)
                        exp_beats.push_back(i * 2 + ((i == model_itr - 1) ? 1 : 0));
                    pc = (pc + 1) % 1024;
                end
                3'd2: begin
                    model_itr = int'(w[21:16]);
                    pc = (pc + 1) % 1024;
                end
                3'd3: pc = w[3] ? (((pc + word_off(w[15:4])) % 1024) + 1024) % 1024
                                : (pc + 1) % 1024;
                default: pc = (pc + 1) % 1024;
            endcase
        end
    endtask

    // BRAM with one-cycle read latency, decoder-side ready driver, and output monitor
    initial begin
        vec_ready  = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_rdata = rd_pend ? mem[rd_addr] : $urandom();
            rd_pend = imem_en;
            rd_addr = imem_addr;
            if (imem_en) mon_fetch.push_back(int'(imem_addr));
            if (issue) mon_issue.push_back(instr);
            if (busy) busy_cycles++;
            if (done) done_count++;
            if (vec_valid) begin
                vec_cycles++;
                if (ready_force0) vec_ready = 1'b0;
                else if (ready_pat.size() > 0) vec_ready = ready_pat.pop_front() != 0;
                else vec_ready = ready_rand ? ($urandom_range(0, 1) != 0) : 1'b1;
                if (vec_ready) mon_beats.push_back(int'(elem_idx) * 2 + int'(vec_last));
            end else begin
                vec_ready = ($urandom_range(0, 1) != 0);
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    endtask

    task automatic compare_run(input string name);
        check({name, ".done_cnt"}, done_count, 1);
        check({name, ".fetch_n"}, mon_fetch.size(), exp_fetch.size());
        for (int i = 0; i < exp_fetch.size() && i < mon_fetch.size(); i++)
            check({name, ".fetch"}, mon_fetch[i], exp_fetch[i]);
        check({name, ".issue_n"}, mon_issue.size(), exp_issue.size());
        for (int i = 0; i < exp_issue.size() && i < mon_issue.size(); i++)
            check({name, ".issue"}, mon_issue[i], exp_issue[i]);
        check({name, ".beat_n"}, mon_beats.size(), exp_beats.size());
        for (int i = 0; i < exp_beats.size() && i < mon_beats.size(); i++)
            check({name, ".beat"}, mon_beats[i], exp_beats[i]);
        check({name, ".busy_cyc"}, busy_cycles, 3 * exp_issue.size() + vec_cycles + 1);
        check({name, ".idle"}, busy, 1'b0);
    endtask

    task automatic run_prog(input string name, input int base, input int hold);
        model_run(base);
        @(negedge clk);
        mon_fetch.delete(); mon_issue.delete(); mon_beats.delete();
        busy_cycles = 0; vec_cycles = 0; done_count = 0;
        start = 1'b1;
        prog_base = base[9:0];
        @(negedge clk);
        for (int i = 0; i < hold; i++) begin
            prog_base = 10'($urandom());
            @(negedge clk);
        end
        start = 1'b0;
        for (int c = 0; c < 3000 && done_count == 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        compare_run(name);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        prog_base = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        check("rst.imem_en", imem_en, 1'b0);
        check("rst.imem_addr", imem_addr, 10'd0);
        check("rst.instr", instr, 32'd0);
        check("rst.issue", issue, 1'b0);
        check("rst.vec_valid", vec_valid, 1'b0);
        check("rst.vec_last", vec_last, 1'b0);
        check("rst.elem_idx", elem_idx, 6'd0);
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of a stalled vector stream
        clear_mem();
        mem[40] = enc(3'd2, 1'b0, 12'h0, 6'd8, 8'h11);
        mem[41] = enc(3'd4, 1'b0, 12'h0, 6'd0, 8'h12);
        ready_force0 = 1'b1;
        start = 1'b1; prog_base = 10'd40;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 50 && !vec_valid; c++) @(negedge clk);
        check("t1.vec_valid", vec_valid, 1'b1);
        repeat (3) @(negedge clk);
        check("t1.hold_idx", elem_idx, 6'd0);
        check("t1.hold_valid", vec_valid, 1'b1);
        check("t1.hold_last", vec_last, 1'b0);
        check("t1.hold_addr", imem_addr, 10'd41);
        rst = 1'b0;
        @(negedge clk);
        check("t1.busy", busy, 1'b0);
        check("t1.vec_valid0", vec_valid, 1'b0);
        check("t1.pc", imem_addr, 10'd0);
        check("t1.instr", instr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ready_force0 = 1'b0;
        model_itr = 1;
        // itr_q restored to 1: a lone vector op gives one last beat
        mem[50] = enc(3'd4, 1'b0, 12'h0, 6'd0, 8'h13);
        run_prog("t1.itr1", 50, 0);
        check("t1.itr1_beat", (mon_beats.size() > 0) ? mon_beats[0] : -1, 1);
        run_prog("t1.rerun", 40, 0);
        check("t1.rerun_first", (mon_fetch.size() > 0) ? mon_fetch[0] : -1, 40);

        // {addi, HALT} from base 5
        clear_mem();
        mem[5] = enc(3'd1, 1'b0, 12'h0, 6'd0, 8'h21);
        run_prog("t2", 5, 0);
        check("t2.busy7", busy_cycles, 7);

        // bne taken backward / forward, then not taken
        clear_mem();
        mem[9]  = enc(3'd3, 1'b1, 12'hFFC, 6'd0, 8'h03);
        mem[7]  = enc(3'd1, 1'b0, 12'h0, 6'd0, 8'h31);
        mem[8]  = enc(3'd3, 1'b1, 12'h006, 6'd0, 8'h32);
        mem[11] = 32'h0;
        run_prog("t3a", 9, 0);
        check("t3a.to7", (mon_fetch.size() > 1) ? mon_fetch[1] : -1, 7);
        check("t3a.to11", (mon_fetch.size() > 3) ? mon_fetch[3] : -1, 11);
        clear_mem();
        mem[9] = enc(3'd3, 1'b0, 12'hFFC, 6'd0, 8'h04);
        run_prog("t3b", 9, 0);
        check("t3b.to10", (mon_fetch.size() > 1) ? mon_fetch[1] : -1, 10);

        // ITR=4 vector with ready pattern 1,0,1,1,1
        clear_mem();
        mem[20] = enc(3'd2, 1'b0, 12'h0, 6'd4, 8'h41);
        mem[21] = enc(3'd4, 1'b0, 12'h0, 6'd0, 8'h42);
        ready_pat = '{1, 0, 1, 1, 1};
        run_prog("t4", 20, 0);
        check("t4.vec_cycles", vec_cycles, 5);
        check("t4.last_beat", (mon_beats.size() > 3) ? mon_beats[3] : -1, 7);
        check("t4.next_pc", (mon_fetch.size() > 2) ? mon_fetch[2] : -1, 22);

        // ITR=0 vector: no beats
        clear_mem();
        mem[30] = enc(3'd2, 1'b0, 12'h0, 6'd0, 8'h51);
        mem[31] = enc(3'd4, 1'b0, 12'h0, 6'd0, 8'h52);
        run_prog("t5", 30, 0);
        check("t5.no_vec", vec_cycles, 0);
        check("t5.next_pc", (mon_fetch.size() > 2) ? mon_fetch[2] : -1, 32);

        // PC wrap, with start/prog_base toggled while busy
        clear_mem();
        mem[1023] = enc(3'd1, 1'b0, 12'h0, 6'd0, 8'h61);
        run_prog("t6", 1023, 3);
        check("t6.wrap", (mon_fetch.size() > 1) ? mon_fetch[1] : -1, 0);

        // Randomized programs with random ready back-pressure
        ready_rand = 1'b1;
        for (int p = 0; p < 8; p++) begin
            int base, len, r;
            clear_mem();
            base = $urandom_range(0, 1023);
            len  = $urandom_range(2, 7);
            for (int i = 0; i < len; i++) begin
                logic [7:0] tag;
                tag = 8'($urandom_range(1, 255));
                r = $urandom_range(0, 9);
                if (r < 4)      mem[(base + i) % 1024] = enc(3'd1, 1'b0, 12'($urandom()), 6'($urandom()), tag);
                else if (r < 6) mem[(base + i) % 1024] = enc(3'd2, 1'b0, 12'h0, 6'($urandom_range(0, 5)), tag);
                else if (r < 8) mem[(base + i) % 1024] = enc(3'd4, 1'b0, 12'h0, 6'($urandom()), tag);
                else            mem[(base + i) % 1024] = enc(3'd3, 1'($urandom_range(0, 1)),
                                                             12'(2 * $urandom_range(1, 2)), 6'h0, tag);
            end
            run_prog("rand", base, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
